packet_upsizer_gearbox: RTL and testbench
=========================================

Name: packet_upsizer_gearbox

Overview:
- Single-clock, store-and-forward packet width converter: collects a framed stream of IN_WIDTH-bit beats and packs RATIO beats per output word (first beat in LSBs).
- Replays each accepted packet as a contiguous word stream with valid/ready, last and keep flags.
- Filters glitch packets, drops oversize packets and aborts stalled transmissions through a watchdog.
- Sits between the nibble-rate Ethernet-side receiver and the wide Aurora-side transmitter, after clock-domain crossing.

Parameters:
- IN_WIDTH, 4, bits per input beat.
- RATIO, 2, input beats per output word (>=2); output width OUT_W = IN_WIDTH*RATIO.
- DEPTH_LOG2, 11, buffer depth in output words = 2**DEPTH_LOG2.
- MIN_PKT_WORDS, 4, packets shorter than this many words are discarded as glitches.
- WATCHDOG_MAX_COUNT, 25, consecutive stalled cycles (out_ready low while enable_out high) before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- enable_in  in  1  packet frame; high for the whole packet, one beat per cycle.
- data_in  in  IN_WIDTH  input beat, valid when enable_in is high.
- enable_out  out  1  output word valid.
- out_ready  in  1  downstream accepts the word when enable_out and out_ready are both high.
- data_out  out  OUT_W  packed word.
- last_out  out  1  high with the final word of a packet.
- keep_out  out  RATIO  valid sub-beats of the current word; bit i = sub-beat i.
- len_out  out  DEPTH_LOG2+1  word count of the packet being sent; stable while enable_out is high.
- drop_pkt  out  1  one-cycle pulse on a glitch, oversize, busy or watchdog drop.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, counters cleared. Buffer contents are don't-care. Asserting rst mid-packet abandons the packet silently, with no drop_pkt pulse.
- Start condition: capture starts only on a rising edge of enable_in seen in IDLE (enable_in high, previous cycle low). If enable_in is already high on entry to IDLE, the rest of that packet is ignored.
- FILL:
  - Each enable_in cycle writes data_in to sub-beat (beat_cnt mod RATIO) of word (beat_cnt / RATIO).
  - Sub-beat 0 occupies bits [IN_WIDTH-1:0].
  - Unwritten sub-beats of a partial final word read as 0.
- Oversize: if beat RATIO*2**DEPTH_LOG2 + 1 arrives, go to DRAIN. DRAIN waits for enable_in low, pulses drop_pkt, then returns to IDLE.
- CHECK: entered on the first cycle enable_in is low after FILL.
  - words = ceil(beat_cnt/RATIO).
  - If words < MIN_PKT_WORDS: pulse drop_pkt, return to IDLE.
  - Otherwise latch len_out and go to SEND.
- SEND:
  - enable_out rises exactly 2 cycles after the first low cycle of enable_in, presenting word 0.
  - Word k is held, with data_out/last_out/keep_out stable, until accepted.
  - On acceptance, word k+1 is presented on the next cycle, so there are no bubbles while out_ready stays high.
  - last_out is high only on word len_out-1.
  - keep_out is all ones except on the last word when beat_cnt mod RATIO = r != 0; then keep_out = (1<<r)-1.
  - After the last word is accepted, enable_out drops the next cycle and the state returns to IDLE.
- Watchdog:
  - A counter increments each SEND cycle with out_ready low and clears on any acceptance.
  - Reaching WATCHDOG_MAX_COUNT deasserts enable_out the next cycle, pulses drop_pkt and returns to IDLE.
- Busy drop: a rising edge of enable_in in CHECK or SEND pulses drop_pkt once. That packet is discarded; SEND is unaffected.
- Counters are DEPTH_LOG2+1 bits plus a log2(RATIO) sub-beat index and never wrap within a packet.

Test Plan:
- Reset, then 10 beats 0x1..0xA (IN_WIDTH=4, RATIO=2), out_ready=1 -> 5 words 0x21,0x43,0x65,0x87,0xA9; enable_out rises 2 cycles after enable_in falls; last_out on 0xA9; keep_out=2'b11; len_out=5.
- 9 beats 0x1..0x9 -> last word 0x09, keep_out=2'b01, len_out=5.
- 6 beats (3 words < 4) -> drop_pkt single pulse, enable_out never rises.
- During SEND hold out_ready low for 3 cycles mid-packet -> data_out stable, no loss. Then hold it low for 25 cycles -> drop_pkt, enable_out low, busy low.
- New packet rising edge during SEND -> drop_pkt once, current packet completes intact; next packet after IDLE accepted.
- DEPTH_LOG2=3, 17 beats -> DRAIN, drop_pkt after enable_in falls, no output. Assert rst mid-FILL -> all outputs 0 immediately, next packet normal.

Source files
------------

// File: rtl/packet_upsizer_gearbox.sv
// Store-and-forward upsizer: packs RATIO narrow beats per word into a buffer,
// then replays the packet with valid/ready, last, keep and a stall watchdog.
module packet_upsizer_gearbox #(
  parameter int IN_WIDTH           = 4,
  parameter int RATIO              = 2,
  parameter int DEPTH_LOG2         = 11,
  parameter int MIN_PKT_WORDS      = 4,
  parameter int WATCHDOG_MAX_COUNT = 25,
  localparam int OUT_W             = IN_WIDTH * RATIO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_in,
  input  logic [IN_WIDTH-1:0]   data_in,
  output logic                  enable_out,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      data_out,
  output logic                  last_out,
  output logic [RATIO-1:0]      keep_out,
  output logic [DEPTH_LOG2:0]   len_out,
  output logic                  drop_pkt,
  output logic                  busy
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam int SW = $clog2(RATIO);
  localparam int WW = $clog2(WATCHDOG_MAX_COUNT + 1);
  localparam logic [CW-1:0] FULL_WORDS = CW'(1) << DEPTH_LOG2;

  typedef enum logic [2:0] {IDLE, FILL, DRAIN, CHECK, SEND} state_t;

  state_t                          state_q, state_d;
  logic                            en_prev_q;
  logic [CW-1:0]                   wc_q, wc_d, len_q, len_d, ptr_q, ptr_d;
  logic [SW-1:0]                   sb_q, sb_d;
  logic [RATIO-1:0][IN_WIDTH-1:0]  asm_q, asm_d, merged;
  logic [WW-1:0]                   wd_q, wd_d;
  logic                            drop_q, drop_d;
  logic [OUT_W-1:0]                data_q;
  logic [OUT_W-1:0]                mem [2**DEPTH_LOG2];

  logic                            wr_en, rd_en, take_beat, rise, is_last;
  logic [DEPTH_LOG2-1:0]           wr_addr, rd_addr;
  logic [OUT_W-1:0]                wr_data;
  logic [CW-1:0]                   wc, words, nxt_ptr;
  logic [SW-1:0]                   sb;
  logic [RATIO-1:0]                keep_part;

  // A packet start behaves as if the counters were already cleared.
  assign wc      = (state_q == IDLE) ? '0 : wc_q;
  assign sb      = (state_q == IDLE) ? '0 : sb_q;
  assign rise    = enable_in && !en_prev_q;
  assign words   = wc_q + CW'(sb_q != '0);
  assign nxt_ptr = ptr_q + CW'(1);
  assign is_last = (ptr_q == len_q - CW'(1));

  // Current beat merged into the partially assembled word; higher sub-beats stay 0.
  always_comb begin
    merged    = '0;
    keep_part = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (SW'(i) == sb)      merged[i] = data_in;
      else if (SW'(i) < sb)  merged[i] = asm_q[i];
      keep_part[i] = (sb_q == '0) || (SW'(i) < sb_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    wc_d      = wc_q;
    sb_d      = sb_q;
    asm_d     = asm_q;
    len_d     = len_q;
    ptr_d     = ptr_q;
    wd_d      = wd_q;
    drop_d    = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = wc_q[DEPTH_LOG2-1:0];
    wr_data   = asm_q;
    rd_en     = 1'b0;
    rd_addr   = '0;
    take_beat = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        state_d   = FILL;
        take_beat = 1'b1;
      end
      FILL: begin
        if (enable_in) take_beat = 1'b1;
        else begin
          state_d = CHECK;
          wr_en   = (sb_q != '0);
        end
      end
      DRAIN: if (!enable_in) begin
        drop_d  = 1'b1;
        state_d = IDLE;
      end
      CHECK: begin
        if (rise) drop_d = 1'b1;
        if (words < CW'(MIN_PKT_WORDS)) begin
          drop_d  = 1'b1;
          state_d = IDLE;
        end else begin
          len_d   = words;
          ptr_d   = '0;
          wd_d    = '0;
          rd_en   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (rise) drop_d = 1'b1;
        if (out_ready) begin
          wd_d = '0;
          if (is_last) state_d = IDLE;
          else begin
            ptr_d   = nxt_ptr;
            rd_en   = 1'b1;
            rd_addr = nxt_ptr[DEPTH_LOG2-1:0];
          end
        end else if (wd_q == WW'(WATCHDOG_MAX_COUNT - 1)) begin
          drop_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A beat beyond a completely full buffer turns the packet into a drain.
    if (take_beat) begin
      if (wc == FULL_WORDS) state_d = DRAIN;
      else if (sb == SW'(RATIO - 1)) begin
        wr_en   = 1'b1;
        wr_addr = wc[DEPTH_LOG2-1:0];
        wr_data = merged;
        wc_d    = wc + CW'(1);
        sb_d    = '0;
      end else begin
        asm_d = merged;
        wc_d  = wc;
        sb_d  = sb + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      en_prev_q <= 1'b0;
      wc_q      <= '0;
      sb_q      <= '0;
      asm_q     <= '0;
      len_q     <= '0;
      ptr_q     <= '0;
      wd_q      <= '0;
      drop_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      en_prev_q <= enable_in;
      wc_q      <= wc_d;
      sb_q      <= sb_d;
      asm_q     <= asm_d;
      len_q     <= len_d;
      ptr_q     <= ptr_d;
      wd_q      <= wd_d;
      drop_q    <= drop_d;
      if (rd_en) data_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign enable_out = (state_q == SEND);
  assign data_out   = data_q;
  assign last_out   = enable_out && is_last;
  assign keep_out   = !enable_out ? '0 : (is_last ? keep_part : '1);
  assign len_out    = len_q;
  assign drop_pkt   = drop_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_packet_upsizer_gearbox.sv
// Directed bench for packet_upsizer_gearbox (IN_WIDTH=4, RATIO=2, 8-word buffer).
module tb_packet_upsizer_gearbox;

  logic       clk = 1'b0;
  logic       rst, enable_in, out_ready;
  logic [3:0] data_in;
  logic       enable_out, last_out, drop_pkt, busy;
  logic [7:0] data_out;
  logic [1:0] keep_out;
  logic [3:0] len_out;

  int checks = 0;
  int errors = 0;
  int drops  = 0;

  typedef struct { logic [7:0] d; logic l; logic [1:0] k; logic [3:0] n; } rx_t;
  rx_t rxq[$];

  typedef struct {
    int n; int base; int exp_drop; int exp_words;
    logic [7:0] exp_last; logic [1:0] exp_keep;
  } vec_t;
  vec_t vt[7];

  packet_upsizer_gearbox #(
    .IN_WIDTH(4), .RATIO(2), .DEPTH_LOG2(3), .MIN_PKT_WORDS(4), .WATCHDOG_MAX_COUNT(25)
  ) dut (
    .clk(clk), .rst(rst), .enable_in(enable_in), .data_in(data_in),
    .enable_out(enable_out), .out_ready(out_ready), .data_out(data_out),
    .last_out(last_out), .keep_out(keep_out), .len_out(len_out),
    .drop_pkt(drop_pkt), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (enable_out && out_ready) rxq.push_back('{data_out, last_out, keep_out, len_out});
    if (drop_pkt) drops++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mword(input int base, input int n, input int k);
    logic [3:0] lo, hi;
    lo = (2*k < n)     ? 4'((base + 2*k) & 15)     : 4'h0;
    hi = (2*k + 1 < n) ? 4'((base + 2*k + 1) & 15) : 4'h0;
    return {hi, lo};
  endfunction

  task automatic send_pkt(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      enable_in = 1'b1;
      data_in   = 4'((base + i) & 15);
    end
    @(posedge clk); #1;
    enable_in = 1'b0;
    data_in   = 4'h0;
  endtask

  task automatic wait_idle(input int lim);
    int t = 0;
    @(negedge clk);
    while (busy && t < lim) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string nm);
    int t = 0;
    while (!enable_out && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 32'(enable_out), 32'd1);
  endtask

  task automatic check_rx(input string nm, input int q0, input int base, input int n, input int words);
    chk({nm, "_count"}, 32'(rxq.size() - q0), 32'(words));
    if (rxq.size() - q0 == words) begin
      for (int k = 0; k < words; k++) begin
        chk({nm, "_data"}, 32'(rxq[q0+k].d), 32'(mword(base, n, k)));
        chk({nm, "_last"}, 32'(rxq[q0+k].l), 32'(k == words - 1));
        chk({nm, "_keep"}, 32'(rxq[q0+k].k), (k == words - 1 && (n % 2) == 1) ? 32'd1 : 32'd3);
        chk({nm, "_len"},  32'(rxq[q0+k].n), 32'(words));
      end
    end
  endtask

  initial begin
    int q0, d0, cnt;
    vt[0] = '{10, 1, 0, 5, 8'hA9, 2'b11};
    vt[1] = '{ 9, 1, 0, 5, 8'h09, 2'b01};
    vt[2] = '{ 6, 1, 1, 0, 8'h00, 2'b00};
    vt[3] = '{ 7, 2, 0, 4, 8'h08, 2'b01};
    vt[4] = '{ 8, 5, 0, 4, 8'hCB, 2'b11};
    vt[5] = '{16, 1, 0, 8, 8'h0F, 2'b11};
    vt[6] = '{ 1, 7, 1, 0, 8'h00, 2'b00};

    rst = 1'b1; enable_in = 1'b0; out_ready = 1'b1; data_in = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_enable_out", 32'(enable_out), 0);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_drop",       32'(drop_pkt), 0);
    chk("rst_data",       32'(data_out), 0);
    chk("rst_len_keep",   32'({len_out, keep_out, last_out}), 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      q0 = rxq.size(); d0 = drops;
      send_pkt(vt[v].n, vt[v].base);
      if (vt[v].exp_words > 0) begin
        @(negedge clk); chk("lat_fill",  32'(enable_out), 0);
        @(negedge clk); chk("lat_check", 32'(enable_out), 0);
        @(negedge clk); chk("lat_send",  32'(enable_out), 1);
      end
      wait_idle(100);
      chk("vec_drops", 32'(drops - d0), 32'(vt[v].exp_drop));
      check_rx("vec", q0, vt[v].base, vt[v].n, vt[v].exp_words);
      if (vt[v].exp_words > 0 && rxq.size() - q0 == vt[v].exp_words) begin
        chk("vec_last_word", 32'(rxq[rxq.size()-1].d), 32'(vt[v].exp_last));
        chk("vec_last_keep", 32'(rxq[rxq.size()-1].k), 32'(vt[v].exp_keep));
      end
    end

    // Short stall mid-packet: word 1 must be held until accepted.
    q0 = rxq.size(); d0 = drops;
    send_pkt(10, 1);
    wait_valid("stall_valid");
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold_data",  32'(data_out), 32'h43);
      chk("stall_hold_valid", 32'(enable_out), 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle(100);
    check_rx("stall", q0, 1, 10, 5);
    chk("stall_drops", 32'(drops - d0), 0);

    // Watchdog: 25 stalled cycles abort the transmission.
    q0 = rxq.size(); d0 = drops;
    out_ready = 1'b0;
    send_pkt(10, 1);
    wait_valid("wd_valid");
    cnt = 0;
    while (enable_out && cnt < 60) begin
      cnt++;
      @(negedge clk);
    end
    chk("wd_cycles", 32'(cnt), 32'd25);
    chk("wd_drop",   32'(drop_pkt), 1);
    chk("wd_busy",   32'(busy), 0);
    @(negedge clk);
    chk("wd_drop_pulse", 32'(drop_pkt), 0);
    out_ready = 1'b1;
    wait_idle(100);
    chk("wd_words", 32'(rxq.size() - q0), 0);
    chk("wd_drops", 32'(drops - d0), 1);

    // New packet during SEND is dropped; current one completes; next accepted.
    q0 = rxq.size(); d0 = drops;
    out_ready = 1'b0;
    send_pkt(10, 1);
    wait_valid("busy_valid");
    send_pkt(6, 3);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle(100);
    check_rx("busy_a", q0, 1, 10, 5);
    chk("busy_drops", 32'(drops - d0), 1);
    q0 = rxq.size(); d0 = drops;
    send_pkt(8, 3);
    wait_idle(100);
    check_rx("busy_c", q0, 3, 8, 4);
    chk("busy_c_drops", 32'(drops - d0), 0);

    // Oversize: 17 beats into an 8-word buffer drain and drop after enable_in falls.
    q0 = rxq.size(); d0 = drops;
    send_pkt(17, 1);
    @(negedge clk);
    chk("over_no_early_drop", 32'(drops - d0), 0);
    chk("over_busy", 32'(busy), 1);
    @(negedge clk);
    chk("over_drop", 32'(drop_pkt), 1);
    wait_idle(100);
    chk("over_drops", 32'(drops - d0), 1);
    chk("over_words", 32'(rxq.size() - q0), 0);

    // Reset mid-FILL: outputs clear at once, no drop, next packet normal.
    d0 = drops;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      enable_in = 1'b1;
      data_in   = 4'(i + 1);
    end
    @(posedge clk); #1 rst = 1'b1; enable_in = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_outs", 32'({enable_out, drop_pkt, last_out, keep_out, len_out}), 0);
    chk("mrst_data", 32'(data_out), 0);
    @(posedge clk); #1 rst = 1'b0;
    q0 = rxq.size();
    send_pkt(8, 9);
    wait_idle(100);
    check_rx("mrst_next", q0, 9, 8, 4);
    chk("mrst_drops", 32'(drops - d0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
